// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, instruction field view and destination selection.
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned FLAG_W = 3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // R-type field layout; I-type immediate occupies {rd, shamt, funct}
   typedef struct packed {
      logic [5:0]        opcode;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [4:0]        shamt;
      logic [5:0]        funct;
   } instr_f_t;

   typedef struct packed {
      logic              we;
      logic [REG_AW-1:0] addr;
   } dest_t;

   // Split a raw instruction word into its fields
   function automatic instr_f_t fields(input logic [XLEN-1:0] w);
      return instr_f_t'(w);
   endfunction

   // Writeback destination of a retiring instruction; r0 never written
   function automatic dest_t dest_sel(input logic [5:0] op, input logic [5:0] funct,
                                      input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
      dest_t d;
      d.we   = 1'b0;
      d.addr = '0;
      if (op == OP_RTYPE && funct != FN_JR) begin
         d.we   = 1'b1;
         d.addr = rd;
      end else if (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI}) begin
         d.we   = 1'b1;
         d.addr = rt;
      end else if (op inside {OP_BEQ, OP_BNE, OP_LW, OP_SW}) begin
         d.we   = 1'b0;
      end
      if (d.addr == '0) d.we = 1'b0;
      return d;
   endfunction

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   // Instructions whose signed overflow is reportable
   function automatic logic is_ovf_op(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_ADDI) || (op == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB));
   endfunction

endpackage

// File: rtl/mips_issue_stage_if.sv
// Issue-stage handshake and ALU bus; slave is the stage, master is upstream/downstream/ALU.
interface mips_issue_stage_if;
   import mips_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_instruction;
   logic [XLEN-1:0]   alu_instruction;
   logic [XLEN-1:0]   alu_regA;
   logic [XLEN-1:0]   alu_regB;
   logic [XLEN-1:0]   alu_result;
   logic [FLAG_W-1:0] alu_flags;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in_valid, in_instruction, alu_result, alu_flags, out_ready,
      output in_ready, alu_instruction, alu_regA, alu_regB, out_valid
   );

   modport master (
      output in_valid, in_instruction, alu_result, alu_flags, out_ready,
      input  in_ready, alu_instruction, alu_regA, alu_regB, out_valid
   );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 GPR file: two bypassed operand reads, one debug read, one synchronous write.
module mips_regfile
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ra_i,
   input  logic [REG_AW-1:0] rb_i,
   input  logic [REG_AW-1:0] dbg_addr_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic [XLEN-1:0]   rdata_a_o,
   output logic [XLEN-1:0]   rdata_b_o,
   output logic [XLEN-1:0]   dbg_data_o
);

   logic [XLEN-1:0] regs_q [NUM_REGS];

   // Operand read with same-cycle write forwarding
   function automatic logic [XLEN-1:0] rd_port(input logic [REG_AW-1:0] a,
                                              input logic [XLEN-1:0] stored);
      if (a == '0)                      return '0;
      else if (we_i && waddr_i == a)    return wdata_i;
      else                              return stored;
   endfunction

   assign rdata_a_o  = rd_port(ra_i, regs_q[ra_i]);
   assign rdata_b_o  = rd_port(rb_i, regs_q[rb_i]);
   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

   // Reset clears the file; r0 is never written
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != '0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/mips_issue_stage.sv
// Operand-issue stage feeding the combinational alu; writes back on retire.
// Optional build macro MIPS_OVF_TRAP_EN: overflowing add/addi/sub suppress writeback
// and pulse exc_overflow; otherwise results always written and exc_overflow stays 0.
module mips_issue_stage
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   mips_issue_stage_if.slave bus,
   output logic              branch_taken,
   output logic              exc_overflow,
   output logic [XLEN-1:0]   retire_count,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data
);

   logic            s_valid_q, s_valid_d;
   logic [XLEN-1:0] s_instr_q, s_instr_d;
   logic [XLEN-1:0] s_a_q, s_a_d;
   logic [XLEN-1:0] s_b_q, s_b_d;
   logic [XLEN-1:0] retire_count_q, retire_count_d;
   logic            branch_q, branch_d;
   logic            ovf_q, ovf_d;

   logic            accept, retire, wr_en;
   logic [XLEN-1:0] rdata_a, rdata_b;
   instr_f_t        in_f, s_f;
   dest_t           dest;
   logic            unused_ok;

   assign in_f   = fields(bus.in_instruction);
   assign s_f    = fields(s_instr_q);
   assign dest   = dest_sel(s_f.opcode, s_f.funct, s_f.rt, s_f.rd);

   assign bus.in_ready = !s_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign retire       = s_valid_q && bus.out_ready;

   assign unused_ok = ^{in_f.opcode, in_f.rd, in_f.shamt, in_f.funct,
                        s_f.rs, s_f.shamt, bus.alu_flags[1:0]};

   mips_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .ra_i       (in_f.rs),
      .rb_i       (in_f.rt),
      .dbg_addr_i (dbg_addr),
      .we_i       (wr_en),
      .waddr_i    (dest.addr),
      .wdata_i    (bus.alu_result),
      .rdata_a_o  (rdata_a),
      .rdata_b_o  (rdata_b),
      .dbg_data_o (dbg_data)
   );

   // Next-state for the pipeline register, retire counter, events and writeback
   always_comb begin
      s_valid_d      = s_valid_q;
      s_instr_d      = s_instr_q;
      s_a_d          = s_a_q;
      s_b_d          = s_b_q;
      retire_count_d = retire_count_q;
      branch_d       = 1'b0;
      ovf_d          = 1'b0;
      wr_en          = 1'b0;

      if (accept) begin
         s_valid_d = 1'b1;
         s_instr_d = bus.in_instruction;
         s_a_d     = rdata_a;
         s_b_d     = rdata_b;
      end else if (retire) begin
         s_valid_d = 1'b0;
      end

      if (retire) begin
         retire_count_d = retire_count_q + XLEN'(1);
         branch_d       = is_branch(s_f.opcode) && bus.alu_flags[2];
         wr_en          = dest.we;
`ifdef MIPS_OVF_TRAP_EN
         if (is_ovf_op(s_f.opcode, s_f.funct) && bus.alu_flags[0]) begin
            wr_en = 1'b0;
            ovf_d = 1'b1;
         end
`endif
      end
   end

   // Stage state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid_q      <= 1'b0;
         s_instr_q      <= '0;
         s_a_q          <= '0;
         s_b_q          <= '0;
         retire_count_q <= '0;
         branch_q       <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         s_valid_q      <= s_valid_d;
         s_instr_q      <= s_instr_d;
         s_a_q          <= s_a_d;
         s_b_q          <= s_b_d;
         retire_count_q <= retire_count_d;
         branch_q       <= branch_d;
         ovf_q          <= ovf_d;
      end
   end

   assign bus.out_valid       = s_valid_q;
   assign bus.alu_instruction = s_instr_q;
   assign bus.alu_regA        = s_a_q;
   assign bus.alu_regB        = s_b_q;
   assign branch_taken        = branch_q;
   assign exc_overflow        = ovf_q;
   assign retire_count        = retire_count_q;

endmodule

// File: tb/tb_mips_issue_stage.sv
// Bench for mips_issue_stage: vector table for the issue stream, ALU stub, scoreboard.
module tb_mips_issue_stage;
   import mips_pkg::*;

   logic        clk;
   logic        reset;
   logic        branch_taken, exc_overflow;
   logic [31:0] retire_count, dbg_data;
   logic [4:0]  dbg_addr;

   mips_issue_stage_if bus ();

   mips_issue_stage dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .branch_taken (branch_taken),
      .exc_overflow (exc_overflow),
      .retire_count (retire_count),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ALU stub: small functional alu, or forced result/flags
   logic        stub_force;
   logic [31:0] force_res;
   logic [2:0]  force_flags;
   logic [31:0] stub_res, imm_s, a_v, b_v;
   logic        stub_v;
   logic [5:0]  st_op, st_fn;

   always_comb begin
      a_v      = bus.alu_regA;
      b_v      = bus.alu_regB;
      st_op    = bus.alu_instruction[31:26];
      st_fn    = bus.alu_instruction[5:0];
      imm_s    = {{16{bus.alu_instruction[15]}}, bus.alu_instruction[15:0]};
      stub_res = '0;
      stub_v   = 1'b0;
      case (st_op)
         OP_RTYPE: begin
            if (st_fn == FN_SUB) begin
               stub_res = a_v - b_v;
               stub_v   = (a_v[31] != b_v[31]) && (stub_res[31] != a_v[31]);
            end else begin
               stub_res = a_v + b_v;
               stub_v   = (a_v[31] == b_v[31]) && (stub_res[31] != a_v[31]);
            end
         end
         OP_ADDI, OP_ADDIU: begin
            stub_res = a_v + imm_s;
            stub_v   = (a_v[31] == imm_s[31]) && (stub_res[31] != a_v[31]);
         end
         OP_ORI:         stub_res = a_v | {16'h0000, bus.alu_instruction[15:0]};
         OP_BEQ, OP_BNE: stub_res = a_v - b_v;
         default:        stub_res = '0;
      endcase
      bus.alu_result = stub_force ? force_res : stub_res;
      bus.alu_flags  = stub_force ? force_flags : {stub_res == 32'h0, stub_res[31], stub_v};
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard of issued instructions and the operands they must carry
   typedef struct {
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
   } sb_t;
   sb_t sb_q[$];

   // One clock starting from a negedge: pop on retire, push on accept
   task automatic cycle(input logic [31:0] ea, input logic [31:0] eb);
      sb_t e;
      #1;
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got retire with empty scoreboard, expected none");
         end else begin
            e = sb_q.pop_front();
            chk("sb_instr", bus.alu_instruction, e.instr);
            chk("sb_regA", bus.alu_regA, e.a);
            chk("sb_regB", bus.alu_regB, e.b);
         end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back('{bus.in_instruction, ea, eb});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
      dbg_addr = a;
      #1;
      chk(name, dbg_data, exp);
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [4:0]  chk_addr;
      logic [31:0] chk_val;
   } vec_t;
   vec_t vecs[6];

   logic [31:0] ori8, addi9;

   initial begin
      vecs[0] = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1),     32'h0,  32'h0, 5'd1, 32'h1};
      vecs[1] = '{enc_r(5'd1, 5'd1, 5'd2, FN_ADD),        32'h1,  32'h1, 5'd2, 32'h2};
      vecs[2] = '{enc_i(OP_ORI, 5'd2, 5'd5, 16'h00F0),    32'h2,  32'h0, 5'd5, 32'hF2};
      vecs[3] = '{enc_r(5'd5, 5'd1, 5'd6, FN_SUB),        32'hF2, 32'h1, 5'd6, 32'hF1};
      vecs[4] = '{enc_i(OP_ADDI, 5'd1, 5'd0, 16'd7),      32'h1,  32'h0, 5'd0, 32'h0};
      vecs[5] = '{enc_r(5'd1, 5'd0, 5'd7, FN_JR),         32'h1,  32'h0, 5'd7, 32'h0};

      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_instruction = '0;
      bus.out_ready  = 1'b1;
      dbg_addr       = '0;
      stub_force     = 1'b0;
      force_res      = '0;
      force_flags    = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_retire_count", retire_count, 32'h0);
      chk("rst_branch", 32'(branch_taken), 32'h0);
      chk("rst_ovf", 32'(exc_overflow), 32'h0);
      for (int a = 0; a < 32; a++) peek(5'(a), 32'h0, "rst_gpr");
      @(negedge clk);

      // Back-to-back issue stream with bypass
      for (int i = 0; i < 6; i++) begin
         bus.in_valid       = 1'b1;
         bus.in_instruction = vecs[i].instr;
         cycle(vecs[i].exp_a, vecs[i].exp_b);
      end
      bus.in_valid = 1'b0;
      cycle(32'h0, 32'h0);
      for (int i = 0; i < 6; i++) peek(vecs[i].chk_addr, vecs[i].chk_val, "stream_gpr");
      chk("stream_count", retire_count, 32'd6);
      @(negedge clk);

      // Backpressure: one entry held three cycles, then retire+accept on one edge
      ori8  = enc_i(OP_ORI, 5'd1, 5'd8, 16'h0005);
      addi9 = enc_i(OP_ADDI, 5'd8, 5'd9, 16'h0001);
      bus.out_ready      = 1'b0;
      bus.in_valid       = 1'b1;
      bus.in_instruction = ori8;
      cycle(32'h1, 32'h0);
      bus.in_instruction = addi9;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
         chk("bp_alu_instr", bus.alu_instruction, ori8);
         chk("bp_regA", bus.alu_regA, 32'h1);
         chk("bp_regB", bus.alu_regB, 32'h0);
         cycle(32'h5, 32'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
      cycle(32'h5, 32'h0);
      bus.in_valid = 1'b0;
      cycle(32'h0, 32'h0);
      peek(5'd8, 32'h5, "bp_gpr8");
      peek(5'd9, 32'h6, "bp_gpr9");
      chk("bp_count", retire_count, 32'd8);
      @(negedge clk);

      // Taken beq: one-cycle pulse, no writeback
      stub_force         = 1'b1;
      force_res          = 32'hFFFF_0000;
      force_flags        = 3'b000;
      bus.in_valid       = 1'b1;
      bus.in_instruction = enc_i(OP_ORI, 5'd0, 5'd1, 16'h0000);
      cycle(32'h0, 32'h1);
      bus.in_instruction = enc_i(OP_BEQ, 5'd1, 5'd1, 16'h0800);
      cycle(32'hFFFF_0000, 32'hFFFF_0000);
      stub_force   = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("br_before", 32'(branch_taken), 32'h0);
      cycle(32'h0, 32'h0);
      #1;
      chk("br_pulse", 32'(branch_taken), 32'h1);
      chk("br_no_ovf", 32'(exc_overflow), 32'h0);
      peek(5'd1, 32'hFFFF_0000, "br_gpr1");
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("br_pulse_end", 32'(branch_taken), 32'h0);
      chk("br_count", retire_count, 32'd10);
      @(negedge clk);

      // Overflowing addi
      stub_force         = 1'b1;
      force_res          = 32'h8000_0000;
      force_flags        = 3'b001;
      bus.in_valid       = 1'b1;
      bus.in_instruction = enc_i(OP_ADDI, 5'd0, 5'd3, 16'h0001);
      cycle(32'h0, 32'h0);
      bus.in_valid = 1'b0;
      cycle(32'h0, 32'h0);
      stub_force = 1'b0;
      #1;
`ifdef MIPS_OVF_TRAP_EN
      chk("ovf_pulse", 32'(exc_overflow), 32'h1);
      peek(5'd3, 32'h0, "ovf_gpr3");
`else
      chk("ovf_pulse", 32'(exc_overflow), 32'h0);
      peek(5'd3, 32'h8000_0000, "ovf_gpr3");
`endif
      chk("ovf_count", retire_count, 32'd11);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("ovf_pulse_end", 32'(exc_overflow), 32'h0);
      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      @(negedge clk);

      // Reset while add $4 is in flight
      bus.out_ready      = 1'b0;
      bus.in_valid       = 1'b1;
      bus.in_instruction = enc_r(5'd1, 5'd1, 5'd4, FN_ADD);
      cycle(32'hFFFF_0000, 32'hFFFF_0000);
      bus.in_valid = 1'b0;
      #1;
      chk("inflight_valid", 32'(bus.out_valid), 32'h1);
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      #1;
      chk("rst2_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst2_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst2_alu_instr", bus.alu_instruction, 32'h0);
      chk("rst2_regA", bus.alu_regA, 32'h0);
      chk("rst2_regB", bus.alu_regB, 32'h0);
      chk("rst2_branch", 32'(branch_taken), 32'h0);
      chk("rst2_ovf", 32'(exc_overflow), 32'h0);
      chk("rst2_count", retire_count, 32'h0);
      peek(5'd4, 32'h0, "rst2_gpr4");
      peek(5'd1, 32'h0, "rst2_gpr1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_issue_stage.md
# mips_issue_stage

Operand-issue stage directly upstream of the combinational `alu`. Accepts one MIPS instruction per cycle over a valid/ready handshake and reads `rs`/`rt` from an internal 32x32 register file. Holds the instruction and operands in a single pipeline register that drives the `alu` inputs. When the entry retires, writes `alu` `result` back to the register file and reports branch and overflow events.

## Interface
- `NUM_REGS`, default 32: register count; fixed at 32 for the MIPS encoding.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: upstream offers `in_instruction`.
- `in_ready`  out  1: stage can accept this cycle.
- `in_instruction`  in  32: raw MIPS word.
- `alu_instruction`  out  32: to `alu.instruction`.
- `alu_regA`  out  32: GPR[rs], to `alu.regA`.
- `alu_regB`  out  32: GPR[rt], to `alu.regB`.
- `alu_result`  in  32: from `alu.result`.
- `alu_flags`  in  3: from `alu.flags`, ordered {zero, negative, overflow}.
- `out_valid`  out  1: pipeline register holds a live instruction.
- `out_ready`  in  1: downstream consumes; retire = `out_valid && out_ready`.
- `branch_taken`  out  1: one-cycle pulse; retired beq/bne had `alu_flags[2]=1`.
- `exc_overflow`  out  1: one-cycle pulse; retired add/addi/sub had `alu_flags[0]=1`.
- `retire_count`  out  32: retired-instruction counter; wraps.
- `dbg_addr`  in  5: debug read address.
- `dbg_data`  out  32: combinational GPR[dbg_addr]; address 0 always reads 0.

## Operation
- Pipeline register: `s_valid`, `s_instr`, `s_a`, `s_b`. The `alu_*` outputs are driven straight from it. `out_valid = s_valid`.
- `in_ready = !s_valid || out_ready`. Accept = `in_valid && in_ready`.
- On accept: `s_instr <= in_instruction`, `s_a <= GPR[rs]`, `s_b <= GPR[rt]`, `s_valid <= 1`.
- Retire without a same-cycle accept: `s_valid <= 0`.
- No accept and no retire: all stage registers hold.
- Destination on retire:
  - opcode 000000, funct not 001000: write rd.
  - opcodes 001000–001110 (addi, addiu, slti, sltiu, andi, ori, xori): write rt.
  - beq, bne, lw, sw: no write.
  - Writes to r0 are discarded.
- Same-cycle accept and retire: the read of rs/rt bypasses the retiring write, so the new instruction sees the new value. No stall.
- `branch_taken` and `exc_overflow` are registered, asserted the cycle after the retire edge, and last one cycle.
- `retire_count` increments by 1 per retire. 0xFFFF_FFFF wraps to 0.
- Reset:
  - `s_valid`, `s_instr`, `s_a`, `s_b`, all GPRs, `retire_count`, `branch_taken` and `exc_overflow` go to 0.
  - An in-flight instruction is discarded and is not written back.
  - `in_ready` reads 1 in the first cycle after reset.

## Timing
- Accept at edge N: `alu_*` valid and `out_valid=1` during cycle N+1.
- Retire at edge M: GPR write visible on `dbg_data` and to the next read from cycle M+1. Event pulses are high during cycle M+1.
- Throughput: one instruction per cycle while `out_ready=1`.
- `out_ready=0` with `s_valid=1`: `in_ready=0`; `alu_*` outputs are stable.
- Combinational paths:
  - `out_ready` to `in_ready`.
  - `alu_result` to the GPR write data.
  - `dbg_addr` to `dbg_data`.

## Configuration
- `MIPS_OVF_TRAP_EN` defined:
  - Retiring add, addi or sub with `alu_flags[0]=1` suppresses the GPR write.
  - `exc_overflow` pulses.
  - `retire_count` still increments.
- `MIPS_OVF_TRAP_EN` undefined:
  - The result is always written.
  - `exc_overflow` is tied to 0.

## Structure
- Package `mips_pkg`:
  - Opcode constants (RTYPE, ADDI..XORI, BEQ, BNE, LW, SW).
  - Funct constants (ADD, SUB, JR).
  - A field-extract helper (rs/rt/rd/opcode/funct).
  - `dest_sel` function returning {write_en, dest_addr}.
- Sub-module `mips_regfile`:
  - 32x32, two combinational read ports plus one debug read port, one synchronous write port.
  - r0 hardwired to 0.
  - Write-to-read bypass.
  - Synchronous reset clears all entries.

## Test plan
- Reset then GPR preload: after reset, `dbg_data=0` for all 32 addresses; `in_ready=1`, `out_valid=0`, `retire_count=0`.
- addi $1,$0,1 then add $2,$1,$1 back-to-back with `out_ready=1`: second issue sees `alu_regA=alu_regB=1` through the bypass; GPR[2]=2; `retire_count=2`.
- Backpressure: hold `out_ready=0` for 3 cycles with one entry loaded: `in_ready=0`; `alu_*` unchanged; on release, one retire and the next accept occur on the same edge.
- beq $1,$1 with GPR[1]=0xFFFF_0000 and `alu_flags=100`: `branch_taken` high for exactly one cycle; no GPR write.
- addi $3,$0,… where the `alu` returns overflow (GPR[0]+1 forced via a stub returning flags 001, result 0x8000_0000): with `MIPS_OVF_TRAP_EN`, GPR[3] unchanged and `exc_overflow` pulses; without it, GPR[3]=0x8000_0000 and `exc_overflow=0`.
- Reset asserted while `s_valid=1` holding add $4: no write to GPR[4]; all outputs 0 the next cycle; `retire_count` unchanged from 0.
